// File: rtl/usb_wb_pkg.sv
// usb_wb_pkg
//   Shared definitions for the Wishbone requester arbiter in front of the USB core slave port.
//   Contents:
//     arb_state_t      arbiter FSM states (IDLE, OWNED)
//     WB_CTI_*         Wishbone cycle-type encodings
//     WB_BTE_*         Wishbone burst-type encodings
//     DEF_*            default parameter values used by usb_wb_arbiter
package usb_wb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [2:0] WB_CTI_CONST   = 3'b001;
    localparam logic [2:0] WB_CTI_INCR    = 3'b010;
    localparam logic [2:0] WB_CTI_EOB     = 3'b111;

    localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;
    localparam logic [1:0] WB_BTE_WRAP4   = 2'b01;
    localparam logic [1:0] WB_BTE_WRAP8   = 2'b10;
    localparam logic [1:0] WB_BTE_WRAP16  = 2'b11;

    localparam int DEF_NUM_MASTERS = 2;
    localparam int DEF_ADR_W       = 30;
    localparam int DEF_DAT_W       = 32;
    localparam int DEF_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/usb_wb_rr_pick.sv
// usb_wb_rr_pick
//   Combinational rotating-priority picker. Starting from the requester just after the last
//   owner (wrapping N-1 -> 0), grants the first active request.
// Ports:
//   req   in  [N-1:0]  active requests
//   last  in  [N-1:0]  one-hot last owner (search starts at the next index)
//   gnt   out [N-1:0]  one-hot pick, all zero when no request is active
module usb_wb_rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] last,
    output logic [N-1:0] gnt
);

    always_comb begin
        int   last_idx;
        int   idx;
        logic found;

        last_idx = 0;
        for (int i = 0; i < N; i++) begin
            if (last[i]) begin
                last_idx = i;
            end
        end

        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        // Walk N positions starting after the last owner; the last owner itself is
        // checked last, so a lone requester still wins back-to-back rounds.
        for (int k = 1; k <= N; k++) begin
            idx = (last_idx + k) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/usb_wb_arbiter.sv
// usb_wb_arbiter
//   Shares the USB core's single Wishbone slave port between NUM_MASTERS requesters.
//   Round-robin arbitration; the grant is held for the whole bus cycle (m_cyc of the owner),
//   with one dead cycle between owners. Optional watchdog (macro WB_TIMEOUT_EN) terminates a
//   strobe that sees no ack/err for TIMEOUT_CYC cycles with a one-cycle err to the owner.
// Ports:
//   clk48_device         in   device clock, rising edge
//   reset_n              in   asynchronous active-low reset
//   m_adr/m_dat_w/m_sel  in   per-master packed request fields, master i at [i*W +: W]
//   m_cyc/m_stb/m_we     in   per-master cycle, strobe, write enable
//   m_cti/m_bte          in   per-master cycle type / burst type
//   m_dat_r              out  slave read data broadcast to all masters
//   m_ack/m_err          out  per-master termination, only the owner can see them
//   s_*                  out/in  Wishbone master side towards the USB core slave port
//   grant                out  one-hot current owner, zero while idle
module usb_wb_arbiter
    import usb_wb_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int ADR_W       = DEF_ADR_W,
    parameter int DAT_W       = DEF_DAT_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                               clk48_device,
    input  logic                               reset_n,
    input  logic [NUM_MASTERS*ADR_W-1:0]       m_adr,
    input  logic [NUM_MASTERS*DAT_W-1:0]       m_dat_w,
    input  logic [NUM_MASTERS*(DAT_W/8)-1:0]   m_sel,
    input  logic [NUM_MASTERS-1:0]             m_cyc,
    input  logic [NUM_MASTERS-1:0]             m_stb,
    input  logic [NUM_MASTERS-1:0]             m_we,
    input  logic [NUM_MASTERS*3-1:0]           m_cti,
    input  logic [NUM_MASTERS*2-1:0]           m_bte,
    output logic [DAT_W-1:0]                   m_dat_r,
    output logic [NUM_MASTERS-1:0]             m_ack,
    output logic [NUM_MASTERS-1:0]             m_err,
    output logic [ADR_W-1:0]                   s_adr,
    output logic [DAT_W-1:0]                   s_dat_w,
    output logic [DAT_W/8-1:0]                 s_sel,
    output logic                               s_cyc,
    output logic                               s_stb,
    output logic                               s_we,
    output logic [2:0]                         s_cti,
    output logic [1:0]                         s_bte,
    input  logic [DAT_W-1:0]                   s_dat_r,
    input  logic                               s_ack,
    input  logic                               s_err,
    output logic [NUM_MASTERS-1:0]             grant
);

    localparam int SEL_W = DAT_W / 8;
    // After reset the search starts at master 0, so the last owner is taken to be N-1.
    localparam logic [NUM_MASTERS-1:0] LAST_RST = {1'b1, {(NUM_MASTERS-1){1'b0}}};

    arb_state_t             state_reg, state_next;
    logic [NUM_MASTERS-1:0] grant_reg, grant_next;
    logic [NUM_MASTERS-1:0] last_reg, last_next;
    logic [NUM_MASTERS-1:0] pick_gnt;

    logic [ADR_W-1:0] mux_adr;
    logic [DAT_W-1:0] mux_dat_w;
    logic [SEL_W-1:0] mux_sel;
    logic             mux_cyc;
    logic             mux_stb;
    logic             mux_we;
    logic [2:0]       mux_cti;
    logic [1:0]       mux_bte;
    logic             force_err;

    usb_wb_rr_pick #(
        .N (NUM_MASTERS)
    ) u_pick (
        .req  (m_cyc),
        .last (last_reg),
        .gnt  (pick_gnt)
    );

    always_ff @(posedge clk48_device or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            last_reg  <= LAST_RST;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            last_reg  <= last_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        last_next  = last_reg;
        case (state_reg)
            IDLE: begin
                if (|m_cyc) begin
                    state_next = OWNED;
                    grant_next = pick_gnt;
                end
            end
            OWNED: begin
                // cti/bte are ignored: only the owner's cyc ends the tenure.
                if (!(|(m_cyc & grant_reg))) begin
                    state_next = IDLE;
                    grant_next = '0;
                    last_next  = grant_reg;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    // grant_reg is zero while idle or in reset, so the mux drives all zeros then.
    always_comb begin
        mux_adr   = '0;
        mux_dat_w = '0;
        mux_sel   = '0;
        mux_cyc   = 1'b0;
        mux_stb   = 1'b0;
        mux_we    = 1'b0;
        mux_cti   = '0;
        mux_bte   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_reg[i]) begin
                mux_adr   = m_adr[i*ADR_W +: ADR_W];
                mux_dat_w = m_dat_w[i*DAT_W +: DAT_W];
                mux_sel   = m_sel[i*SEL_W +: SEL_W];
                mux_cyc   = m_cyc[i];
                mux_stb   = m_stb[i];
                mux_we    = m_we[i];
                mux_cti   = m_cti[i*3 +: 3];
                mux_bte   = m_bte[i*2 +: 2];
            end
        end
    end

`ifdef WB_TIMEOUT_EN
    localparam int                CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             stalled;

    // A slave termination in the same cycle as expiry wins, since stalled excludes it.
    assign stalled   = (state_reg == OWNED) && mux_stb && !s_ack && !s_err;
    assign force_err = stalled && (cnt_reg == CNT_LAST);
    assign cnt_next  = (stalled && !force_err) ? cnt_reg + 1'b1 : '0;

    always_ff @(posedge clk48_device or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end
`else
    assign force_err = 1'b0;

    // Without the watchdog TIMEOUT_CYC has no effect; this block only references it.
    if (TIMEOUT_CYC < 1) begin : g_timeout_unused
    end
`endif

    assign s_adr   = mux_adr;
    assign s_dat_w = mux_dat_w;
    assign s_sel   = mux_sel;
    assign s_cyc   = mux_cyc;
    assign s_stb   = mux_stb & ~force_err;
    assign s_we    = mux_we;
    assign s_cti   = mux_cti;
    assign s_bte   = mux_bte;
    assign m_dat_r = s_dat_r;
    assign grant   = grant_reg;

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_term
        assign m_ack[gi] = grant_reg[gi] & s_ack;
        assign m_err[gi] = grant_reg[gi] & (s_err | force_err);
    end

endmodule
